// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module : ssd_pkg
// Brief  : Shared types, constants and helpers for the SSD display arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        BLANK = 2'd2
    } ssd_state_e;

    localparam int unsigned c_num_req    = 2;
    localparam logic [3:0]  c_blank_mode = 4'b0000;

    // Sole requester wins; on a tie the requester that did not own last wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last_owner);
        if (req == 2'b11) begin
            return ~last_owner;
        end
        return req[1];
    endfunction

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_arb_timer.sv
`default_nettype none
// ============================================================================
// Module : ssd_arb_timer
// Brief  : Clear/enable saturating counter with a terminal-count compare.
// Rev    : 1.0 - initial release
// ============================================================================
module ssd_arb_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_val,
    output logic             at_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign at_tc = (r_cnt >= tc_val);

endmodule
`default_nettype wire

// File: rtl/ssd_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ssd_display_arbiter
// Brief  : Round-robin owner of a shared 4-digit SSD with hold limit and blank gap.
// Rev    : 1.0 - initial release
// ============================================================================
module ssd_display_arbiter
    import ssd_pkg::*;
#(
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned MAX_HOLD     = 10000000,
    parameter int unsigned BLANK_CYCLES = 2000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_num_req-1:0] req,
    input  logic [15:0]          digits_r0,
    input  logic [3:0]           mode_r0,
    input  logic [15:0]          digits_r1,
    input  logic [3:0]           mode_r1,
    output logic [c_num_req-1:0] gnt,
    output logic [c_num_req-1:0] revoked,
    output logic [3:0]           digit3,
    output logic [3:0]           digit2,
    output logic [3:0]           digit1,
    output logic [3:0]           digit0,
    output logic [3:0]           mode
);

    localparam logic [CNT_W-1:0] c_hold_tc  = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] c_blank_tc = CNT_W'(BLANK_CYCLES - 1);

    ssd_state_e                 r_state;
    logic                       r_owner;
    logic                       r_last_owner;
    logic [c_num_req-1:0]       r_gnt;
    logic [c_num_req-1:0]       r_revoked;
    logic [15:0]                r_digits;
    logic [3:0]                 r_mode;

    logic w_hold_tc;
    logic w_blank_tc;
    logic w_own_req;
    logic w_other_req;
    logic w_release;
    logic w_preempt;
    logic w_leave;
    logic w_arb_slot;
    logic w_grant;
    logic w_winner;

    assign w_own_req   = req[r_owner];
    assign w_other_req = req[~r_owner];
    assign w_release   = (r_state == OWN) && !w_own_req;
    assign w_preempt   = (r_state == OWN) && (MAX_HOLD != 0) && w_hold_tc && w_other_req;
    assign w_leave     = w_release || w_preempt;
    assign w_arb_slot  = (r_state == IDLE) || ((r_state == BLANK) && w_blank_tc);
    assign w_grant     = w_arb_slot && (req != 2'b00);
    assign w_winner    = pick_winner(req, r_last_owner);

    ssd_arb_timer #(.CNT_W(CNT_W)) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_grant),
        .en     (r_state == OWN),
        .tc_val (c_hold_tc),
        .at_tc  (w_hold_tc)
    );

    ssd_arb_timer #(.CNT_W(CNT_W)) u_blank_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_leave),
        .en     (r_state == BLANK),
        .tc_val (c_blank_tc),
        .at_tc  (w_blank_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_gnt        <= '0;
            r_revoked    <= '0;
            r_digits     <= '0;
            r_mode       <= c_blank_mode;
        end else begin
            r_revoked <= '0;
            case (r_state)
                IDLE, BLANK: begin
                    if (w_grant) begin
                        r_state      <= OWN;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_gnt        <= onehot(w_winner);
                    end else if (w_arb_slot) begin
                        r_state <= IDLE;
                    end
                end
                OWN: begin
                    if (w_leave) begin
                        r_state  <= BLANK;
                        r_gnt    <= '0;
                        r_digits <= '0;
                        r_mode   <= c_blank_mode;
                        // A simultaneous release wins over pre-emption: no pulse.
                        if (!w_release) begin
                            r_revoked <= onehot(r_owner);
                        end
                    end else begin
                        r_digits <= r_owner ? digits_r1 : digits_r0;
                        r_mode   <= r_owner ? mode_r1 : mode_r0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign revoked = r_revoked;
    assign digit3  = r_digits[15:12];
    assign digit2  = r_digits[11:8];
    assign digit1  = r_digits[7:4];
    assign digit0  = r_digits[3:0];
    assign mode    = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_ssd_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ssd_display_arbiter
// Brief  : Self-checking bench; two arbiters (MAX_HOLD 8 and 0) vs a reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ssd_display_arbiter;

    localparam int BLANK = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] digits_r0 = '0;
    logic [15:0] digits_r1 = '0;
    logic [3:0]  mode_r0 = '0;
    logic [3:0]  mode_r1 = '0;

    logic [1:0] gnt_a, rev_a, gnt_b, rev_b;
    logic [3:0] d3_a, d2_a, d1_a, d0_a, mode_a;
    logic [3:0] d3_b, d2_b, d1_b, d0_b, mode_b;
    logic [23:0] act_a, act_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ssd_display_arbiter #(.CNT_W(8), .MAX_HOLD(8), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .req(req),
        .digits_r0(digits_r0), .mode_r0(mode_r0),
        .digits_r1(digits_r1), .mode_r1(mode_r1),
        .gnt(gnt_a), .revoked(rev_a),
        .digit3(d3_a), .digit2(d2_a), .digit1(d1_a), .digit0(d0_a),
        .mode(mode_a)
    );

    ssd_display_arbiter #(.CNT_W(8), .MAX_HOLD(0), .BLANK_CYCLES(BLANK)) dut_nh (
        .clk(clk), .rst(rst), .req(req),
        .digits_r0(digits_r0), .mode_r0(mode_r0),
        .digits_r1(digits_r1), .mode_r1(mode_r1),
        .gnt(gnt_b), .revoked(rev_b),
        .digit3(d3_b), .digit2(d2_b), .digit1(d1_b), .digit0(d0_b),
        .mode(mode_b)
    );

    assign act_a = {gnt_a, rev_a, d3_a, d2_a, d1_a, d0_a, mode_a};
    assign act_b = {gnt_b, rev_b, d3_b, d2_b, d1_b, d0_b, mode_b};

    // Reference model: index 0 has MAX_HOLD=8, index 1 never pre-empts.
    int          m_owner[2];
    int          m_held[2];
    int          m_gap[2];
    int          m_last[2];
    logic [1:0]  e_gnt[2];
    logic [1:0]  e_rev[2];
    logic [15:0] e_dig[2];
    logic [3:0]  e_mode[2];

    function automatic logic [23:0] exp_vec(input int k);
        return {e_gnt[k], e_rev[k], e_dig[k], e_mode[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_gap[k]   = 0;
            m_last[k]  = 1;
            e_gnt[k]   = 2'b00;
            e_rev[k]   = 2'b00;
            e_dig[k]   = 16'h0;
            e_mode[k]  = 4'h0;
        end
    endtask

    task automatic model_step(input int k);
        int   hold;
        int   w;
        logic rel;
        logic pre;
        hold     = (k == 0) ? 8 : 0;
        e_rev[k] = 2'b00;
        if (m_owner[k] >= 0) begin
            rel = !req[m_owner[k]];
            pre = (hold != 0) && (m_held[k] + 1 >= hold) && req[1 - m_owner[k]];
            if (rel || pre) begin
                if (!rel) e_rev[k] = (m_owner[k] == 0) ? 2'b01 : 2'b10;
                m_owner[k] = -1;
                m_gap[k]   = BLANK;
                e_gnt[k]   = 2'b00;
                e_dig[k]   = 16'h0;
                e_mode[k]  = 4'h0;
            end else begin
                m_held[k] = m_held[k] + 1;
                e_dig[k]  = (m_owner[k] == 0) ? digits_r0 : digits_r1;
                e_mode[k] = (m_owner[k] == 0) ? mode_r0 : mode_r1;
            end
        end else begin
            if (m_gap[k] > 0) m_gap[k] = m_gap[k] - 1;
            if (m_gap[k] == 0 && req != 2'b00) begin
                if (req == 2'b11) w = 1 - m_last[k];
                else              w = (req == 2'b01) ? 0 : 1;
                m_owner[k] = w;
                m_last[k]  = w;
                m_held[k]  = 0;
                e_gnt[k]   = (w == 0) ? 2'b01 : 2'b10;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_digits();
        digits_r0 = 16'($urandom);
        digits_r1 = 16'($urandom);
        mode_r0   = 4'($urandom);
        mode_r1   = 4'($urandom);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (act_a !== 24'h0) begin
            fails++; $display("FAIL reset_a act=%h exp=%h", act_a, 24'h0);
        end
        tests++;
        if (act_b !== 24'h0) begin
            fails++; $display("FAIL reset_b act=%h exp=%h", act_b, 24'h0);
        end
    endtask

    task automatic test_single_owner();
        do_reset();
        rand_digits();
        digits_r0 = 16'h1234;
        mode_r0   = 4'hF;
        req       = 2'b01;
        tick();
        tests++;
        if (gnt_a !== 2'b01) begin
            fails++; $display("FAIL single_grant act=%b exp=01", gnt_a);
        end
        tick();
        tests++;
        if ({d3_a, d2_a, d1_a, d0_a, mode_a} !== 20'h1234F) begin
            fails++; $display("FAIL single_digits act=%h exp=1234f", {d3_a, d2_a, d1_a, d0_a, mode_a});
        end
        for (int i = 0; i < 50; i++) begin
            rand_digits();
            tick();
            tests++;
            if (gnt_a !== 2'b01 || rev_a !== 2'b00 || act_a !== exp_vec(0)) begin
                fails++; $display("FAIL single_hold cyc=%0d act=%h exp=%h", i, act_a, exp_vec(0));
            end
        end
    endtask

    task automatic test_preempt();
        do_reset();
        rand_digits();
        digits_r1 = 16'hABCD;
        mode_r1   = 4'h5;
        req       = 2'b11;
        tick();
        tests++;
        if (gnt_a !== 2'b01) begin
            fails++; $display("FAIL preempt_first act=%b exp=01", gnt_a);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            tests++;
            if (gnt_a !== 2'b01 || rev_a !== 2'b00) begin
                fails++; $display("FAIL preempt_hold cyc=%0d gnt=%b rev=%b exp gnt=01 rev=00", i, gnt_a, rev_a);
            end
        end
        tick();
        tests++;
        if (rev_a !== 2'b01 || gnt_a !== 2'b00 || mode_a !== 4'h0) begin
            fails++; $display("FAIL preempt_revoke rev=%b gnt=%b mode=%h exp rev=01 gnt=00 mode=0", rev_a, gnt_a, mode_a);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (gnt_a !== 2'b00 || rev_a !== 2'b00 || mode_a !== 4'h0) begin
                fails++; $display("FAIL preempt_blank cyc=%0d gnt=%b rev=%b mode=%h exp 00/00/0", i, gnt_a, rev_a, mode_a);
            end
        end
        tick();
        tests++;
        if (gnt_a !== 2'b10) begin
            fails++; $display("FAIL preempt_handover act=%b exp=10", gnt_a);
        end
        tick();
        tests++;
        if ({d3_a, d2_a, d1_a, d0_a, mode_a} !== 20'hABCD5) begin
            fails++; $display("FAIL preempt_digits act=%h exp=abcd5", {d3_a, d2_a, d1_a, d0_a, mode_a});
        end
    endtask

    task automatic test_release_at_expiry();
        do_reset();
        rand_digits();
        req = 2'b01;
        tick();
        req = 2'b11;
        for (int i = 0; i < 7; i++) tick();
        req = 2'b10;
        tick();
        tests++;
        if (rev_a !== 2'b00 || gnt_a !== 2'b00) begin
            fails++; $display("FAIL expiry_release rev=%b gnt=%b exp rev=00 gnt=00", rev_a, gnt_a);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (gnt_a !== 2'b00) begin
                fails++; $display("FAIL expiry_blank cyc=%0d act=%b exp=00", i, gnt_a);
            end
        end
        tick();
        tests++;
        if (gnt_a !== 2'b10 || act_a !== exp_vec(0)) begin
            fails++; $display("FAIL expiry_handover act=%h exp=%h", act_a, exp_vec(0));
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        rand_digits();
        req = 2'b10;
        tick();
        tests++;
        if (gnt_b !== 2'b10) begin
            fails++; $display("FAIL nohold_grant act=%b exp=10", gnt_b);
        end
        req = 2'b11;
        for (int i = 0; i < 100; i++) begin
            rand_digits();
            tick();
            tests++;
            if (gnt_b !== 2'b10 || rev_b !== 2'b00 || act_b !== exp_vec(1) || act_a !== exp_vec(0)) begin
                fails++; $display("FAIL nohold_keep cyc=%0d b=%h expb=%h a=%h expa=%h", i, act_b, exp_vec(1), act_a, exp_vec(0));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rand_digits();
        mode_r0 = 4'hF;
        req     = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (act_a !== 24'h0 || act_b !== 24'h0) begin
            fails++; $display("FAIL async_reset a=%h b=%h exp=000000", act_a, act_b);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 2'b11;
        tick();
        tests++;
        if (gnt_a !== 2'b01 || gnt_b !== 2'b01) begin
            fails++; $display("FAIL async_regrant a=%b b=%b exp=01", gnt_a, gnt_b);
        end
    endtask

    task automatic test_idle_return();
        do_reset();
        rand_digits();
        req = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        req = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (gnt_a !== 2'b00 || mode_a !== 4'h0 || act_a !== exp_vec(0)) begin
                fails++; $display("FAIL idle_gap cyc=%0d act=%h exp=%h", i, act_a, exp_vec(0));
            end
        end
        req = 2'b10;
        tick();
        tests++;
        if (gnt_a !== 2'b10) begin
            fails++; $display("FAIL idle_regrant act=%b exp=10", gnt_a);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_digits();
            if ($urandom_range(5) == 0) req = 2'($urandom);
            tick();
            tests++;
            if (act_a !== exp_vec(0) || act_b !== exp_vec(1) ||
                (gnt_a & rev_a) != 2'b00 || (gnt_b & rev_b) != 2'b00) begin
                fails++; $display("FAIL random cyc=%0d a=%h expa=%h b=%h expb=%h", i, act_a, exp_vec(0), act_b, exp_vec(1));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_owner();
        test_preempt();
        test_release_at_expiry();
        test_no_preempt();
        test_async_reset();
        test_idle_return();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
